// File: rtl/wimax_pkg.sv
// WiMAX PHY shared constants: randomizer seed, FEC block length and derandomizer state type.
// Used by both the TX randomizer and the RX derandomizer so their sequences always match.
package wimax_pkg;
  localparam logic [1:15] SEED       = 15'b100101010000000;
  localparam int          BLOCK_BITS = 96;

  typedef enum logic {DR_IDLE, DR_RUN} derand_state_t;
endpackage

// File: rtl/prbs_derandomizer_if.sv
// Bit-serial valid/ready stream bus for the derandomizer: upstream input side and downstream output side.
// slave = the derandomizer; master = whatever feeds it and drains it.
interface prbs_derandomizer_if;
  logic i_valid;
  logic i_data;
  logic i_ready;
  logic o_valid;
  logic o_data;
  logic o_last;
  logic o_ready;

  modport slave (
    input  i_valid, i_data, o_ready,
    output i_ready, o_valid, o_data, o_last
  );

  modport master (
    output i_valid, i_data, o_ready,
    input  i_ready, o_valid, o_data, o_last
  );
endinterface

// File: rtl/prbs_lfsr15.sv
// One combinational step of the 1+x^14+x^15 LFSR, register indexed [1:15] as in the WiMAX standard.
// Shared by the TX randomizer and the RX derandomizer.
module prbs_lfsr15 (
  input  logic [1:15] state,
  output logic [1:15] next_state,
  output logic        out_bit
);
  always_comb begin
    out_bit    = state[14] ^ state[15];
    next_state = {out_bit, state[1:14]};
  end
endmodule

// File: rtl/prbs_derandomizer.sv
// WiMAX receive-side PRBS de-whitening with valid/ready backpressure and per-block reseed.
// Optional macro PRBS_DERAND_BYPASS_EN adds a 'bypass' port that passes raw bits while keeping alignment.
module prbs_derandomizer #(
  parameter int BLOCK_BITS = wimax_pkg::BLOCK_BITS,
  parameter int CNT_W      = 7
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
`ifdef PRBS_DERAND_BYPASS_EN
  input  logic bypass,
`endif
  prbs_derandomizer_if.slave bus
);
  import wimax_pkg::*;

  localparam logic [0:0]       ST_IDLE  = DR_IDLE;
  localparam logic [0:0]       ST_RUN   = DR_RUN;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_BITS - 1);

  logic [0:0]       state_q, state_d;
  logic [1:15]      lfsr_q, lfsr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             o_valid_q, o_valid_d;
  logic             o_data_q, o_data_d;
  logic             o_last_q, o_last_d;

  logic [1:15]      lfsr_next;
  logic             prbs_bit;
  logic             i_ready;
  logic             accept;
  logic             last_bit;
  logic             raw_pass;

  prbs_lfsr15 u_lfsr (
    .state      (lfsr_q),
    .next_state (lfsr_next),
    .out_bit    (prbs_bit)
  );

`ifdef PRBS_DERAND_BYPASS_EN
  assign raw_pass = bypass;
`else
  assign raw_pass = 1'b0;
`endif

  always_comb begin
    i_ready  = (state_q == ST_RUN) && en && !load && (!o_valid_q || bus.o_ready);
    accept   = bus.i_valid && i_ready;
    last_bit = (cnt_q == LAST_CNT);

    state_d   = state_q;
    lfsr_d    = lfsr_q;
    cnt_d     = cnt_q;
    o_valid_d = o_valid_q;
    o_data_d  = o_data_q;
    o_last_d  = o_last_q;

    // load restarts the block and drops any pending output bit
    if (load) begin
      state_d   = ST_RUN;
      lfsr_d    = SEED;
      cnt_d     = '0;
      o_valid_d = 1'b0;
      o_last_d  = 1'b0;
    end else if (accept) begin
      o_data_d  = raw_pass ? bus.i_data : (bus.i_data ^ prbs_bit);
      o_valid_d = 1'b1;
      o_last_d  = last_bit;
      if (last_bit) begin
        cnt_d  = '0;
        lfsr_d = SEED;
      end else begin
        cnt_d  = cnt_q + 1'b1;
        lfsr_d = lfsr_next;
      end
    end else if (o_valid_q && bus.o_ready) begin
      o_valid_d = 1'b0;
      o_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      lfsr_q    <= '0;
      cnt_q     <= '0;
      o_valid_q <= 1'b0;
      o_data_q  <= 1'b0;
      o_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      cnt_q     <= cnt_d;
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
      o_last_q  <= o_last_d;
    end
  end

  assign bus.i_ready = i_ready;
  assign bus.o_valid = o_valid_q;
  assign bus.o_data  = o_data_q;
  assign bus.o_last  = o_last_q;
endmodule

// File: tb/tb_prbs_derandomizer.sv
// Self-checking bench for prbs_derandomizer: TX-side PRBS reference model, random payloads and handshakes.
// Define PRBS_DERAND_BYPASS_EN at compile time to also exercise the bypass port.
module tb_prbs_derandomizer;
  localparam int BB = 96;

  logic clk = 1'b0;
  logic rst_n;
  logic load;
  logic en;
`ifdef PRBS_DERAND_BYPASS_EN
  logic bypass;
  bit   bypass_mask[$];
`endif

  prbs_derandomizer_if bus ();

  prbs_derandomizer #(.BLOCK_BITS(BB), .CNT_W(7)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .en     (en),
`ifdef PRBS_DERAND_BYPASS_EN
    .bypass (bypass),
`endif
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  int   tests = 0;
  int   fails = 0;
  bit   prbs[BB];
  bit   in_bits[$];
  bit   exp_data[$];
  bit   exp_last[$];
  bit   rx_data[$];
  bit   rx_last[$];
  int   tx_idx;

  // Randomizer sequence as a recurrence on feedback history: f[n] = f[n-14] ^ f[n-15]
  function automatic void build_prbs();
    bit h[15+BB];
    logic [14:0] s;
    s = 15'b100101010000000;
    for (int i = 0; i < 15; i++) h[i] = s[i];
    for (int n = 0; n < BB; n++) begin
      h[15+n] = h[n+1] ^ h[n];
      prbs[n] = h[15+n];
    end
  endfunction

  // mode 0: random payload scrambled by the TX model; mode 1: all-zero received bits
  function automatic void prep_stream(input int n, input int mode);
    bit p;
    in_bits.delete(); exp_data.delete(); exp_last.delete();
    rx_data.delete(); rx_last.delete();
`ifdef PRBS_DERAND_BYPASS_EN
    bypass_mask.delete();
`endif
    tx_idx = 0;
    for (int k = 0; k < n; k++) begin
      p = (mode == 0) ? bit'($urandom_range(1)) : 1'b0;
      in_bits.push_back((mode == 0) ? (p ^ prbs[k % BB]) : 1'b0);
      exp_data.push_back((mode == 0) ? p : prbs[k % BB]);
      exp_last.push_back((k % BB) == BB - 1);
`ifdef PRBS_DERAND_BYPASS_EN
      bypass_mask.push_back(1'b0);
`endif
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load();
    load = 1'b1;
    bus.i_valid = 1'b0;
    step();
    load = 1'b0;
  endtask

  // Feeds nbits from in_bits and records every popped output; does not drain the final bit
  task automatic run_stream(input int nbits, input bit rnd, output bit timed_out);
    int sent = 0;
    int cyc = 0;
    timed_out = 1'b0;
    while (sent < nbits) begin
      bus.i_valid = rnd ? ($urandom_range(3) != 0) : 1'b1;
      bus.i_data  = in_bits[tx_idx];
      bus.o_ready = rnd ? ($urandom_range(3) != 0) : 1'b1;
      en          = rnd ? ($urandom_range(7) != 0) : 1'b1;
`ifdef PRBS_DERAND_BYPASS_EN
      bypass      = bypass_mask[tx_idx];
`endif
      #1;
      if (bus.o_valid && bus.o_ready) begin
        rx_data.push_back(bus.o_data);
        rx_last.push_back(bus.o_last);
      end
      if (bus.i_valid && bus.i_ready) begin
        sent++;
        tx_idx++;
      end
      step();
      cyc++;
      if (cyc > 20 * nbits + 50) begin
        timed_out = 1'b1;
        break;
      end
    end
    bus.i_valid = 1'b0;
    en = 1'b1;
  endtask

  task automatic drain();
    bus.i_valid = 1'b0;
    bus.o_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (bus.o_valid) begin
        rx_data.push_back(bus.o_data);
        rx_last.push_back(bus.o_last);
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load = 1'b0; en = 1'b1;
    bus.i_valid = 1'b1; bus.i_data = 1'b1; bus.o_ready = 1'b1;
`ifdef PRBS_DERAND_BYPASS_EN
    bypass = 1'b0;
`endif
    step(); step();
    tests++;
    if (bus.o_valid !== 1'b0 || bus.o_data !== 1'b0 || bus.o_last !== 1'b0 || bus.i_ready !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_outputs: got v=%b d=%b l=%b rdy=%b, want all 0",
               bus.o_valid, bus.o_data, bus.o_last, bus.i_ready);
    end
    rst_n = 1'b1;
    step();
    tests++;
    if (bus.i_ready !== 1'b0 || bus.o_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL idle_no_accept: got rdy=%b v=%b, want 0 0", bus.i_ready, bus.o_valid);
    end
    bus.i_valid = 1'b0;
  endtask

  task automatic test_known_seq();
    logic [13:0] pat;
    pat = 14'b00000011111101;
    pulse_load();
    en = 1'b1; bus.o_ready = 1'b1; bus.i_valid = 1'b1; bus.i_data = 1'b0;
    #1;
    tests++;
    if (bus.o_valid !== 1'b0 || bus.i_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL after_load: got v=%b rdy=%b, want v=0 rdy=1", bus.o_valid, bus.i_ready);
    end
    for (int i = 0; i < 14; i++) begin
      step();
      tests++;
      if (bus.o_valid !== 1'b1 || bus.o_data !== pat[13-i]) begin
        fails++;
        $display("[TB] FAIL known_seq bit %0d: got v=%b d=%b, want v=1 d=%b", i, bus.o_valid, bus.o_data, pat[13-i]);
      end
    end
    drain();
  endtask

  task automatic test_loopback();
    bit to;
    prep_stream(3 * BB, 0);
    pulse_load();
    run_stream(3 * BB, 1'b1, to);
    drain();
    tests++;
    if (to || rx_data.size() != exp_data.size()) begin
      fails++;
      $display("[TB] FAIL loopback_count: got %0d bits timeout=%b, want %0d", rx_data.size(), to, exp_data.size());
    end else begin
      for (int k = 0; k < exp_data.size(); k++) begin
        tests++;
        if (rx_data[k] !== exp_data[k] || rx_last[k] !== exp_last[k]) begin
          fails++;
          $display("[TB] FAIL loopback bit %0d: got d=%b l=%b, want d=%b l=%b", k, rx_data[k], rx_last[k], exp_data[k], exp_last[k]);
        end
      end
    end
  endtask

  task automatic test_stall();
    bit to1, to2;
    bit held_d, held_l;
    prep_stream(BB, 0);
    pulse_load();
    run_stream(30, 1'b0, to1);
    held_d = bus.o_data;
    held_l = bus.o_last;
    bus.o_ready = 1'b0;
    bus.i_valid = 1'b1;
    bus.i_data  = in_bits[tx_idx];
    for (int c = 0; c < 5; c++) begin
      #1;
      tests++;
      if (bus.i_ready !== 1'b0 || bus.o_valid !== 1'b1 || bus.o_data !== held_d || bus.o_last !== held_l) begin
        fails++;
        $display("[TB] FAIL stall_hold cycle %0d: got rdy=%b v=%b d=%b l=%b, want 0 1 %b %b",
                 c, bus.i_ready, bus.o_valid, bus.o_data, bus.o_last, held_d, held_l);
      end
      step();
    end
    run_stream(BB - 30, 1'b0, to2);
    drain();
    tests++;
    if (to1 || to2 || rx_data.size() != BB) begin
      fails++;
      $display("[TB] FAIL stall_count: got %0d bits, want %0d", rx_data.size(), BB);
    end else begin
      for (int k = 0; k < BB; k++) begin
        tests++;
        if (rx_data[k] !== exp_data[k] || rx_last[k] !== exp_last[k]) begin
          fails++;
          $display("[TB] FAIL stall bit %0d: got d=%b l=%b, want d=%b l=%b", k, rx_data[k], rx_last[k], exp_data[k], exp_last[k]);
        end
      end
    end
  endtask

  task automatic test_load_midblock();
    bit to;
    prep_stream(BB, 0);
    pulse_load();
    run_stream(40, 1'b0, to);
    bus.o_ready = 1'b0;
    bus.i_valid = 1'b1;
    load = 1'b1;
    #1;
    tests++;
    if (bus.i_ready !== 1'b0 || bus.o_valid !== 1'b1) begin
      fails++;
      $display("[TB] FAIL load_blocks_input: got rdy=%b v=%b, want rdy=0 v=1", bus.i_ready, bus.o_valid);
    end
    step();
    load = 1'b0;
    bus.i_valid = 1'b0;
    tests++;
    if (bus.o_valid !== 1'b0 || bus.o_last !== 1'b0) begin
      fails++;
      $display("[TB] FAIL load_drop: got v=%b l=%b, want 0 0", bus.o_valid, bus.o_last);
    end
    tests++;
    if (to || rx_data.size() != 39) begin
      fails++;
      $display("[TB] FAIL pre_load_count: got %0d bits, want 39", rx_data.size());
    end
    prep_stream(14, 1);
    run_stream(14, 1'b1, to);
    drain();
    tests++;
    if (to || rx_data.size() != 14) begin
      fails++;
      $display("[TB] FAIL post_load_count: got %0d bits, want 14", rx_data.size());
    end else begin
      for (int k = 0; k < 14; k++) begin
        tests++;
        if (rx_data[k] !== exp_data[k] || rx_last[k] !== 1'b0) begin
          fails++;
          $display("[TB] FAIL post_load bit %0d: got d=%b l=%b, want d=%b l=0", k, rx_data[k], rx_last[k], exp_data[k]);
        end
      end
    end
  endtask

  task automatic test_reset_midblock();
    bit to;
    prep_stream(BB, 0);
    pulse_load();
    run_stream(20, 1'b0, to);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    bus.i_valid = 1'b1; en = 1'b1; bus.o_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      tests++;
      if (bus.o_valid !== 1'b0 || bus.o_data !== 1'b0 || bus.o_last !== 1'b0 || bus.i_ready !== 1'b0) begin
        fails++;
        $display("[TB] FAIL reset_midblock cycle %0d: got v=%b d=%b l=%b rdy=%b, want all 0",
                 c, bus.o_valid, bus.o_data, bus.o_last, bus.i_ready);
      end
      step();
    end
    prep_stream(14, 1);
    pulse_load();
    run_stream(14, 1'b0, to);
    drain();
    tests++;
    if (to || rx_data.size() != 14) begin
      fails++;
      $display("[TB] FAIL reset_restart_count: got %0d bits, want 14", rx_data.size());
    end else begin
      for (int k = 0; k < 14; k++) begin
        tests++;
        if (rx_data[k] !== exp_data[k]) begin
          fails++;
          $display("[TB] FAIL reset_restart bit %0d: got %b, want %b", k, rx_data[k], exp_data[k]);
        end
      end
    end
  endtask

`ifdef PRBS_DERAND_BYPASS_EN
  task automatic test_bypass();
    bit to;
    prep_stream(BB, 0);
    for (int k = 10; k < 20; k++) begin
      in_bits[k]     = bit'($urandom_range(1));
      exp_data[k]    = in_bits[k];
      bypass_mask[k] = 1'b1;
    end
    pulse_load();
    run_stream(BB, 1'b1, to);
    drain();
    bypass = 1'b0;
    tests++;
    if (to || rx_data.size() != BB) begin
      fails++;
      $display("[TB] FAIL bypass_count: got %0d bits, want %0d", rx_data.size(), BB);
    end else begin
      for (int k = 0; k < BB; k++) begin
        tests++;
        if (rx_data[k] !== exp_data[k] || rx_last[k] !== exp_last[k]) begin
          fails++;
          $display("[TB] FAIL bypass bit %0d: got d=%b l=%b, want d=%b l=%b", k, rx_data[k], rx_last[k], exp_data[k], exp_last[k]);
        end
      end
    end
  endtask
`endif

  initial begin
    build_prbs();
    test_reset();
    test_known_seq();
    test_loopback();
    test_stall();
    test_load_midblock();
    test_reset_midblock();
`ifdef PRBS_DERAND_BYPASS_EN
    test_bypass();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
